// File: rtl/bip_mem_if.sv
// ROM/RAM bus between the BIP core and its program ROM and data RAM.
// The core drives the addresses and strobes; the memories return data.
interface bip_mem_if #(
  parameter int NB_INSTRUCTION = 16,
  parameter int NB_ADDR        = 11,
  parameter int NB_DATA        = 16
) ();
  logic [NB_INSTRUCTION-1:0] i_rom_data;
  logic [NB_DATA-1:0]        i_ram_data;
  logic [NB_ADDR-1:0]        o_rom_addr;
  logic [NB_ADDR-1:0]        o_ram_addr;
  logic [NB_DATA-1:0]        o_ram_data;
  logic                      o_ram_wr_enable;
  logic                      o_ram_rd_enable;

  modport master (
    input  i_rom_data, i_ram_data,
    output o_rom_addr, o_ram_addr, o_ram_data, o_ram_wr_enable, o_ram_rd_enable
  );
  modport slave (
    output i_rom_data, i_ram_data,
    input  o_rom_addr, o_ram_addr, o_ram_data, o_ram_wr_enable, o_ram_rd_enable
  );
endinterface

// File: rtl/bip_core.sv
// Parametrised BIP accumulator core: EXEC/MEMRD/HALT control with a one-cycle
// RAM read wait state, run enable, halt status and a saturating cycle counter.
module bip_core #(
  parameter int NB_INSTRUCTION = 16,
  parameter int NB_OPCODE      = 5,
  parameter int NB_OPERAND     = NB_INSTRUCTION - NB_OPCODE,
  parameter int NB_ADDR        = 11,
  parameter int NB_DATA        = 16,
  parameter int NB_CYCLES      = 32
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  bip_mem_if.master            mem,
  output logic [NB_DATA-1:0]   o_acc,
  output logic                 o_halt,
  output logic [NB_CYCLES-1:0] o_cycle_count
);
  localparam int NB_SH = $clog2(NB_DATA);
  localparam logic [NB_OPCODE-1:0] OP_HLT = NB_OPCODE'(5'b00000);
  localparam logic [NB_OPCODE-1:0] OP_STO = NB_OPCODE'(5'b00001);
  localparam logic [NB_OPCODE-1:0] OP_LD  = NB_OPCODE'(5'b00010);
  localparam logic [NB_OPCODE-1:0] OP_LDI = NB_OPCODE'(5'b00011);
  localparam logic [NB_OPCODE-1:0] OP_ADD = NB_OPCODE'(5'b00100);
  localparam logic [NB_OPCODE-1:0] OP_ADI = NB_OPCODE'(5'b00101);
  localparam logic [NB_OPCODE-1:0] OP_SUB = NB_OPCODE'(5'b00110);
  localparam logic [NB_OPCODE-1:0] OP_SBI = NB_OPCODE'(5'b00111);
  localparam logic [NB_OPCODE-1:0] OP_AND = NB_OPCODE'(5'b01000);
  localparam logic [NB_OPCODE-1:0] OP_ANI = NB_OPCODE'(5'b01001);
  localparam logic [NB_OPCODE-1:0] OP_OR  = NB_OPCODE'(5'b01010);
  localparam logic [NB_OPCODE-1:0] OP_ORI = NB_OPCODE'(5'b01011);
  localparam logic [NB_OPCODE-1:0] OP_XOR = NB_OPCODE'(5'b01100);
  localparam logic [NB_OPCODE-1:0] OP_XRI = NB_OPCODE'(5'b01101);
  localparam logic [NB_OPCODE-1:0] OP_SLL = NB_OPCODE'(5'b01110);
  localparam logic [NB_OPCODE-1:0] OP_SRA = NB_OPCODE'(5'b01111);
  localparam logic [NB_OPCODE-1:0] OP_BEQ = NB_OPCODE'(5'b10000);
  localparam logic [NB_OPCODE-1:0] OP_BNE = NB_OPCODE'(5'b10001);
  localparam logic [NB_OPCODE-1:0] OP_JMP = NB_OPCODE'(5'b10010);

  typedef enum logic [1:0] {EXEC, MEMRD, HALT} state_t;

  state_t                 r_state, w_state_nxt;
  logic [NB_ADDR-1:0]     r_pc, w_pc_nxt, w_pc_inc, w_target;
  logic [NB_DATA-1:0]     r_acc, w_acc_nxt, w_imm, w_src, w_alu;
  logic [NB_CYCLES-1:0]   r_cnt;
  logic                   w_cnt_en, w_wr, w_rd, w_is_memop;
  logic [NB_OPCODE-1:0]   w_opcode;
  logic [NB_OPERAND-1:0]  w_operand;
  logic signed [NB_OPERAND-1:0] w_operand_s;
  logic [NB_SH-1:0]       w_shamt;

  assign w_opcode    = mem.i_rom_data[NB_INSTRUCTION-1 -: NB_OPCODE];
  assign w_operand   = mem.i_rom_data[NB_OPERAND-1:0];
  assign w_operand_s = w_operand;
  assign w_imm       = NB_DATA'(w_operand_s);
  assign w_target    = w_operand[NB_ADDR-1:0];
  assign w_shamt     = w_operand[NB_SH-1:0];
  assign w_pc_inc    = r_pc + 1'b1;
  // Memory-operand ops are the even opcodes LD..XOR; their odd partners take imm.
  assign w_is_memop  = (w_opcode >= OP_LD) && (w_opcode <= OP_XOR) && !w_opcode[0];
  // ROM is held at the same PC through MEMRD, so the opcode is still valid there.
  assign w_src       = (r_state == MEMRD) ? mem.i_ram_data : w_imm;

  always_comb begin
    w_alu = r_acc;
    case (w_opcode)
      OP_LD,  OP_LDI: w_alu = w_src;
      OP_ADD, OP_ADI: w_alu = r_acc + w_src;
      OP_SUB, OP_SBI: w_alu = r_acc - w_src;
      OP_AND, OP_ANI: w_alu = r_acc & w_src;
      OP_OR,  OP_ORI: w_alu = r_acc | w_src;
      OP_XOR, OP_XRI: w_alu = r_acc ^ w_src;
      OP_SLL:         w_alu = r_acc << w_shamt;
      OP_SRA:         w_alu = NB_DATA'($signed(r_acc) >>> w_shamt);
      default:        w_alu = r_acc;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_acc_nxt   = r_acc;
    w_cnt_en    = 1'b0;
    w_wr        = 1'b0;
    w_rd        = 1'b0;
    case (r_state)
      EXEC: if (i_enable) begin
        w_cnt_en = 1'b1;
        w_pc_nxt = w_pc_inc;
        if (w_is_memop) begin
          w_rd        = 1'b1;
          w_pc_nxt    = r_pc;
          w_state_nxt = MEMRD;
        end else begin
          case (w_opcode)
            OP_HLT: begin
              w_pc_nxt    = r_pc;
              w_state_nxt = HALT;
            end
            OP_STO: w_wr = 1'b1;
            OP_BEQ: if (r_acc == '0) w_pc_nxt = w_target;
            OP_BNE: if (r_acc != '0) w_pc_nxt = w_target;
            OP_JMP: w_pc_nxt = w_target;
            default: w_acc_nxt = w_alu;
          endcase
        end
      end
      MEMRD: begin
        // The RAM word is sampled exactly once, so enable is not consulted here.
        w_cnt_en    = 1'b1;
        w_acc_nxt   = w_alu;
        w_pc_nxt    = w_pc_inc;
        w_state_nxt = EXEC;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= EXEC;
      r_pc    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_acc   <= w_acc_nxt;
      if (w_cnt_en && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign mem.o_rom_addr      = r_pc;
  assign mem.o_ram_addr      = w_target;
  assign mem.o_ram_data      = r_acc;
  assign mem.o_ram_wr_enable = w_wr & i_reset;
  assign mem.o_ram_rd_enable = w_rd & i_reset;
  assign o_acc               = r_acc;
  assign o_halt              = (r_state == HALT);
  assign o_cycle_count       = r_cnt;
endmodule

// File: tb/tb_bip_core.sv
// Bench for bip_core: instruction-level ISA model checked every cycle, plus
// directed programs with hand-computed literal expectations.
module tb_bip_core;
  localparam int NI = 16, NA = 11, ND = 16, NC = 32;
  localparam logic [15:0] NOP = 16'hF800;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  logic [ND-1:0] acc;
  logic          halt;
  logic [NC-1:0] cnt;

  bip_mem_if #(.NB_INSTRUCTION(NI), .NB_ADDR(NA), .NB_DATA(ND)) bus ();

  bip_core #(.NB_INSTRUCTION(NI), .NB_OPCODE(5), .NB_OPERAND(11), .NB_ADDR(NA),
             .NB_DATA(ND), .NB_CYCLES(NC)) dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .mem(bus),
    .o_acc(acc), .o_halt(halt), .o_cycle_count(cnt)
  );

  logic [15:0] rom [2048];
  logic [15:0] ram [2048];

  assign bus.i_rom_data = rom[bus.o_rom_addr];

  // Synchronous RAM: write on the strobe edge, read data valid the cycle after.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2048; i++) ram[i] <= '0;
      bus.i_ram_data <= '0;
    end else begin
      if (bus.o_ram_wr_enable) ram[bus.o_ram_addr] <= bus.o_ram_data;
      if (bus.o_ram_rd_enable) bus.i_ram_data <= ram[bus.o_ram_addr];
    end
  end

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] opd);
    return {op, opd};
  endfunction

  function automatic logic [15:0] alu(input logic [4:0] op, input logic [15:0] a,
                                      input logic [15:0] b);
    case (op)
      5'd2, 5'd3:   return b;
      5'd4, 5'd5:   return a + b;
      5'd6, 5'd7:   return a - b;
      5'd8, 5'd9:   return a & b;
      5'd10, 5'd11: return a | b;
      5'd12, 5'd13: return a ^ b;
      5'd14:        return a << b[3:0];
      5'd15:        return $signed(a) >>> b[3:0];
      default:      return a;
    endcase
  endfunction

  // ISA model: architectural state plus whether a memory-operand read is outstanding.
  logic [10:0] m_pc;
  logic [15:0] m_acc;
  logic [31:0] m_cnt;
  bit          m_halt, m_wait;
  logic [15:0] m_mem [2048];

  always @(negedge clk) begin
    logic [15:0] instr;
    logic [4:0]  op;
    logic [10:0] opd;
    logic [15:0] imm;
    bit          memop, exp_wr, exp_rd;
    instr = rom[m_pc];
    op    = instr[15:11];
    opd   = instr[10:0];
    imm   = {{5{opd[10]}}, opd};
    memop = op inside {5'd2, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12};
    if (!rst) begin
      m_pc = '0; m_acc = '0; m_cnt = '0; m_halt = 0; m_wait = 0;
      for (int i = 0; i < 2048; i++) m_mem[i] = '0;
      chk("rst_pc",  64'(bus.o_rom_addr), 64'(0));
      chk("rst_acc", 64'(acc), 64'(0));
      chk("rst_cnt", 64'(cnt), 64'(0));
      chk("rst_halt", 64'(halt), 64'(0));
      chk("rst_wr", 64'(bus.o_ram_wr_enable), 64'(0));
      chk("rst_rd", 64'(bus.o_ram_rd_enable), 64'(0));
    end else begin
      exp_wr = !m_halt && !m_wait && en && op == 5'd1;
      exp_rd = !m_halt && !m_wait && en && memop;
      chk("pc",   64'(bus.o_rom_addr), 64'(m_pc));
      chk("acc",  64'(acc), 64'(m_acc));
      chk("halt", 64'(halt), 64'(m_halt));
      chk("cnt",  64'(cnt), 64'(m_cnt));
      chk("wr",   64'(bus.o_ram_wr_enable), 64'(exp_wr));
      chk("rd",   64'(bus.o_ram_rd_enable), 64'(exp_rd));
      chk("wdata", 64'(bus.o_ram_data), 64'(m_acc));
      chk("raddr", 64'(bus.o_ram_addr), 64'(opd));
      if (m_wait) chk("rdata", 64'(bus.i_ram_data), 64'(m_mem[opd]));
      if (!m_halt && (m_wait || en)) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (m_wait) begin
          m_acc  = alu(op, m_acc, m_mem[opd]);
          m_pc   = m_pc + 1;
          m_wait = 0;
        end else if (memop) begin
          m_wait = 1;
        end else begin
          case (op)
            5'd0:  m_halt = 1;
            5'd1:  begin m_mem[opd] = m_acc; m_pc = m_pc + 1; end
            5'd16: m_pc = (m_acc == 0) ? opd : m_pc + 1;
            5'd17: m_pc = (m_acc != 0) ? opd : m_pc + 1;
            5'd18: m_pc = opd;
            default: begin m_acc = alu(op, m_acc, imm); m_pc = m_pc + 1; end
          endcase
        end
      end
    end
  end

  task automatic begin_prog();
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 2048; i++) rom[i] = NOP;
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 begin_prog();
    // LDI 5; ADDI 3; STO 10; LD 10; HLT
    rom[0] = ins(5'd3, 11'd5);
    rom[1] = ins(5'd5, 11'd3);
    rom[2] = ins(5'd1, 11'd10);
    rom[3] = ins(5'd2, 11'd10);
    rom[4] = ins(5'd0, 11'd0);
    release_rst();
    step(6);
    chk("t1_acc", 64'(acc), 64'h8);
    chk("t1_ram10", 64'(ram[10]), 64'h8);
    chk("t1_halt", 64'(halt), 64'h1);
    chk("t1_cnt", 64'(cnt), 64'd6);
    step(3);
    chk("t1_pc_frozen", 64'(bus.o_rom_addr), 64'd4);
    chk("t1_cnt_frozen", 64'(cnt), 64'd6);

    // LDI 0x7FF; SUBI 1; SRA 1; SLL 4
    begin_prog();
    rom[0] = ins(5'd3, 11'h7FF);
    rom[1] = ins(5'd7, 11'd1);
    rom[2] = ins(5'd15, 11'd1);
    rom[3] = ins(5'd14, 11'd4);
    release_rst();
    step(1); chk("t2_ldi", 64'(acc), 64'hFFFF);
    step(1); chk("t2_subi", 64'(acc), 64'hFFFE);
    step(1); chk("t2_sra", 64'(acc), 64'hFFFF);
    step(1); chk("t2_sll", 64'(acc), 64'hFFF0);

    // LDI 0; BEQ 7; @7 BNE 3
    begin_prog();
    rom[0] = ins(5'd3, 11'd0);
    rom[1] = ins(5'd16, 11'd7);
    rom[7] = ins(5'd17, 11'd3);
    release_rst();
    step(2); chk("t3_beq_taken", 64'(bus.o_rom_addr), 64'd7);
    step(1); chk("t3_bne_untaken", 64'(bus.o_rom_addr), 64'd8);

    // JMP 2047; NOP at 2047 wraps to 0
    begin_prog();
    rom[0] = ins(5'd18, 11'd2047);
    release_rst();
    step(1); chk("t4_jmp", 64'(bus.o_rom_addr), 64'd2047);
    step(1); chk("t4_wrap", 64'(bus.o_rom_addr), 64'd0);

    // Enable stalls: LDI 9; STO 20; ADD 20; HLT
    begin_prog();
    rom[0] = ins(5'd3, 11'd9);
    rom[1] = ins(5'd1, 11'd20);
    rom[2] = ins(5'd4, 11'd20);
    rom[3] = ins(5'd0, 11'd0);
    release_rst();
    step(1);
    en = 1'b0;
    step(3);
    chk("t5_stall_pc", 64'(bus.o_rom_addr), 64'd1);
    chk("t5_stall_acc", 64'(acc), 64'd9);
    chk("t5_stall_cnt", 64'(cnt), 64'd1);
    chk("t5_stall_ram", 64'(ram[20]), 64'd0);
    en = 1'b1;
    step(1); chk("t5_sto", 64'(ram[20]), 64'd9);
    step(1); chk("t5_memrd_pc", 64'(bus.o_rom_addr), 64'd2);
    en = 1'b0;
    step(1);
    chk("t5_add_acc", 64'(acc), 64'd18);
    chk("t5_add_pc", 64'(bus.o_rom_addr), 64'd3);
    chk("t5_add_cnt", 64'(cnt), 64'd4);
    en = 1'b1;
    step(2);

    // Asynchronous reset during MEMRD: LDI 4; LD 5
    begin_prog();
    rom[0] = ins(5'd3, 11'd4);
    rom[1] = ins(5'd2, 11'd5);
    release_rst();
    step(2);
    chk("t6_in_memrd", 64'(bus.o_rom_addr), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_pc", 64'(bus.o_rom_addr), 64'd0);
    chk("t6_async_acc", 64'(acc), 64'd0);
    chk("t6_async_cnt", 64'(cnt), 64'd0);
    chk("t6_async_rd", 64'(bus.o_ram_rd_enable), 64'd0);
    chk("t6_async_wr", 64'(bus.o_ram_wr_enable), 64'd0);
    release_rst();
    step(1);
    chk("t6_restart_acc", 64'(acc), 64'd4);
    chk("t6_restart_pc", 64'(bus.o_rom_addr), 64'd1);
    step(2);
    chk("t6_ld_acc", 64'(acc), 64'd0);
    chk("t6_ld_pc", 64'(bus.o_rom_addr), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule

// File: doc/bip_core.md
# bip_core

Parametrised accumulator CPU core for the BIP processor: next-generation replacement for the original fixed-width BIP CPU. It adds a configurable data width, logic, shift and branch instructions, a synchronous-read RAM wait state, a run/stall enable, a halt status and a cycle counter. It sits between the combinational program ROM and the synchronous data RAM in the BIP top level.

## Interface
- NB_INSTRUCTION, 16, instruction word width
- NB_OPCODE, 5, opcode field width (instruction MSBs)
- NB_OPERAND, NB_INSTRUCTION-NB_OPCODE, operand field width (instruction LSBs)
- NB_ADDR, 11, ROM/RAM address width; constraint NB_ADDR <= NB_OPERAND
- NB_DATA, 16, accumulator/RAM data width; constraint NB_DATA >= NB_OPERAND
- NB_CYCLES, 32, cycle counter width

- i_clock  in  1  single clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_enable  in  1  run enable; low stalls the core in EXEC
- i_rom_data  in  NB_INSTRUCTION  instruction at o_rom_addr (combinational ROM)
- i_ram_data  in  NB_DATA  RAM read data, valid one cycle after a read request
- o_rom_addr  out  NB_ADDR  program counter
- o_ram_addr  out  NB_ADDR  operand[NB_ADDR-1:0]
- o_ram_data  out  NB_DATA  accumulator value (store data)
- o_ram_wr_enable  out  1  RAM write strobe
- o_ram_rd_enable  out  1  RAM read request
- o_acc  out  NB_DATA  accumulator
- o_halt  out  1  high while in HALT
- o_cycle_count  out  NB_CYCLES  executed-cycle counter

## Operation
- State machine: EXEC, MEMRD, HALT. Reset: state EXEC, PC 0, ACC 0, counter 0, o_halt 0, wr/rd enables 0.
- imm = operand sign-extended to NB_DATA; mem = i_ram_data in MEMRD. All arithmetic is mod 2^NB_DATA, with no flags.
- Opcodes (binary):
  - 00000 HLT: enter HALT; PC unchanged.
  - 00001 STO: RAM[addr] <= ACC.
  - 00010 LD: ACC <= mem.
  - 00011 LDI: ACC <= imm.
  - 00100/00101 ADD/ADDI.
  - 00110/00111 SUB/SUBI.
  - 01000/01001 AND/ANDI.
  - 01010/01011 OR/ORI.
  - 01100/01101 XOR/XORI.
  - 01110 SLL: ACC <= ACC << operand[$clog2(NB_DATA)-1:0].
  - 01111 SRA: arithmetic right shift by the same amount.
  - 10000 BEQ: if ACC==0, PC <= operand[NB_ADDR-1:0].
  - 10001 BNE: if ACC!=0, same target.
  - 10010 JMP: unconditional jump to the same target.
  - All other opcodes: NOP.
- Memory-operand ops (LD, ADD, SUB, AND, OR, XOR):
  - EXEC: assert o_ram_rd_enable and go to MEMRD; PC and ACC hold.
  - MEMRD: ACC updates from mem, PC+1, return to EXEC.
- All other ops complete in one EXEC cycle. Non-branch ops and untaken branches advance PC by 1.
- PC wraps from 2^NB_ADDR-1 to 0.
- RAM control is combinational from state and i_rom_data:
  - wr_enable = EXEC & STO & i_enable & reset deasserted.
  - rd_enable = EXEC & memory-operand op & i_enable & reset deasserted.
  - rd_enable is 0 in MEMRD and HALT.
- i_enable low in EXEC: no register changes and no RAM strobes.
- i_enable low in MEMRD: ignored; the load completes, because the RAM output is sampled exactly once.
- HALT: all registers frozen and strobes 0. Only reset leaves HALT.
- o_cycle_count increments on every EXEC cycle with i_enable=1 and on every MEMRD cycle. It saturates at all-ones.

## Timing
- One-cycle ops: ACC/PC update at the rising edge ending the EXEC cycle.
- Memory-operand ops: 2 cycles. The RAM samples the address on edge 1, data is valid in MEMRD, and ACC updates on edge 2.
- o_ram_addr and o_rom_addr stay stable through MEMRD.
- STO: the RAM write occurs on the edge ending the EXEC cycle.
- o_halt rises on the edge ending the HLT cycle.
- Reset assertion asynchronously clears all state, including mid-MEMRD; the pending load is discarded.
- After reset deassertion, execution starts at PC 0 on the first enabled edge.

## Test plan
- Program LDI 5; ADDI 3; STO 10; LD 10; HLT, with i_enable=1:
  - ACC=8, RAM[10]=8, o_halt=1, o_cycle_count=6, PC stays at 4.
- LDI 0x7FF; SUBI 1; SRA 1; SLL 4 (NB_DATA=16):
  - ACC sequence 0xFFFF, 0xFFFE, 0xFFFF, 0xFFF0.
- LDI 0; BEQ 7 -> PC=7. At 7: BNE 3 (not taken) -> PC=8.
- JMP 2047 with a NOP at 2047 -> PC wraps to 0.
- i_enable low:
  - Low for 3 cycles on a STO: no write strobe, PC/ACC/counter held.
  - Low during the MEMRD of an ADD: ACC updated, PC+1.
- Reset mid-operation:
  - i_reset low during MEMRD: PC=0, ACC=0, counter=0, enables 0 immediately (asynchronous).
  - Restart re-executes from address 0.
